// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe move controller and its board consumers.
// Board vectors are [0:8] so that cell i is bit [i] and cell 0 is the MSB.
// Cell indices are 4 bits wide; codes 9..15 are rejected as illegal moves.
package ttt_pkg;
   localparam int NCELLS = 9;

   typedef logic [3:0] cell_idx_t;
   typedef logic [0:8] board_t;
   typedef enum logic [1:0] {PLAY_A, PLAY_B, EVAL, DONE} turn_state_t;

   localparam cell_idx_t   LAST_CELL = 4'd8;
   localparam logic [3:0]  MAX_MOVES = 4'd9;
endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a synchronous level input.
// Latency: rise is combinational with the cycle in which the input first reads high.
// No backpressure; the delayed copy clears on reset, so a level held through reset counts once.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic rise
);
   logic in_q;

   // Delayed copy of the input for edge comparison
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_q <= 1'b0;
      else     in_q <= in;
   end

   assign rise = in & ~in_q;
endmodule

// File: rtl/turn_ctrl.sv
// Tic-tac-toe move controller: alternates players, rejects bad cells, stops on win or full board.
// Latency: a legal move updates the board at the sampling edge; the next turn begins one edge later.
// No backpressure; moves arriving during EVAL or DONE are dropped without flagging illegal.
module turn_ctrl
   import ttt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  cell_idx_t  sel,
   input  logic       place,
   input  logic       new_game,
   input  logic       wina,
   input  logic       winb,
   output board_t     inp1,
   output board_t     inp2,
   output logic       turn,
   output logic       illegal,
   output logic       game_over,
   output logic       draw,
   output logic [3:0] move_cnt
);
   turn_state_t state, state_nxt;
   board_t      inp1_nxt, inp2_nxt;
   logic [3:0]  cnt_nxt;
   logic        mover, mover_nxt;
   logic        starter, starter_nxt;
   logic        illegal_nxt, over_nxt, draw_nxt;
   logic        go, ng_rise, occupied;

   edge_det u_place_edge (.clk(clk), .rst(rst), .in(place),    .rise(go));
   edge_det u_ng_edge    (.clk(clk), .rst(rst), .in(new_game), .rise(ng_rise));

   // State, board and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PLAY_A;
         inp1      <= '0;
         inp2      <= '0;
         move_cnt  <= 4'd0;
         mover     <= 1'b0;
         starter   <= 1'b0;
         illegal   <= 1'b0;
         game_over <= 1'b0;
         draw      <= 1'b0;
      end else begin
         state     <= state_nxt;
         inp1      <= inp1_nxt;
         inp2      <= inp2_nxt;
         move_cnt  <= cnt_nxt;
         mover     <= mover_nxt;
         starter   <= starter_nxt;
         illegal   <= illegal_nxt;
         game_over <= over_nxt;
         draw      <= draw_nxt;
      end
   end

   // Next-state, move acceptance and end-of-game evaluation
   always_comb begin
      state_nxt   = state;
      inp1_nxt    = inp1;
      inp2_nxt    = inp2;
      cnt_nxt     = move_cnt;
      mover_nxt   = mover;
      starter_nxt = starter;
      illegal_nxt = 1'b0;
      over_nxt    = game_over;
      draw_nxt    = draw;

      // Out-of-range indices never touch the board vectors
      occupied = 1'b0;
      if (sel <= LAST_CELL) occupied = inp1[sel] | inp2[sel];

      if (new_game) begin
         // Clears every cycle while held; the opening player flips only once per press
         inp1_nxt    = '0;
         inp2_nxt    = '0;
         cnt_nxt     = 4'd0;
         over_nxt    = 1'b0;
         draw_nxt    = 1'b0;
         starter_nxt = starter ^ ng_rise;
         state_nxt   = starter_nxt ? PLAY_B : PLAY_A;
      end else begin
         case (state)
            PLAY_A, PLAY_B: begin
               if (go) begin
                  if (sel > LAST_CELL || occupied) begin
                     illegal_nxt = 1'b1;
                  end else begin
                     if (state == PLAY_A) inp1_nxt[sel] = 1'b1;
                     else                 inp2_nxt[sel] = 1'b1;
                     cnt_nxt   = (move_cnt == MAX_MOVES) ? move_cnt : move_cnt + 4'd1;
                     mover_nxt = (state == PLAY_B);
                     state_nxt = EVAL;
                  end
               end
            end
            EVAL: begin
               // Win flags come back from the evaluator during this single cycle
               if (wina || winb || move_cnt == MAX_MOVES) begin
                  state_nxt = DONE;
                  over_nxt  = 1'b1;
                  draw_nxt  = ~wina & ~winb & (move_cnt == MAX_MOVES);
               end else begin
                  state_nxt = mover ? PLAY_A : PLAY_B;
               end
            end
            default: ;
         endcase
      end
   end

   // Player indicator: who moves next, or who made the final move once the game is over
   always_comb begin
      case (state)
         PLAY_A:  turn = 1'b0;
         PLAY_B:  turn = 1'b1;
         EVAL:    turn = ~mover;
         default: turn = mover;
      endcase
   end
endmodule

// File: tb/tb_turn_ctrl.sv
// Randomised and directed bench for turn_ctrl with a cell-ownership reference model.
// The model tracks owners per cell and a play/evaluate/finished phase, and is compared every cycle.
// A line-win function stands in for the downstream evaluator driving wina/winb.
module tb_turn_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sel = 4'd0;
   logic       place = 1'b0;
   logic       new_game = 1'b0;
   logic       wina, winb;
   logic [0:8] inp1, inp2;
   logic       turn, illegal, game_over, draw;
   logic [3:0] move_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic bit line_win(input logic [0:8] b);
      return (b[0] && b[1] && b[2]) || (b[3] && b[4] && b[5]) || (b[6] && b[7] && b[8]) ||
             (b[0] && b[3] && b[6]) || (b[1] && b[4] && b[7]) || (b[2] && b[5] && b[8]) ||
             (b[0] && b[4] && b[8]) || (b[2] && b[4] && b[6]);
   endfunction

   assign wina = line_win(inp1);
   assign winb = line_win(inp2);

   turn_ctrl dut (
      .clk(clk), .rst(rst), .sel(sel), .place(place), .new_game(new_game),
      .wina(wina), .winb(winb), .inp1(inp1), .inp2(inp2), .turn(turn),
      .illegal(illegal), .game_over(game_over), .draw(draw), .move_cnt(move_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int PH_PLAY = 0, PH_EVAL = 1, PH_DONE = 2;
   int owner[9];          // 0 empty, 1 player A, 2 player B
   int phase, to_move, last_mover, starter, moves;
   bit prev_place, prev_ng, m_ill, m_over, m_draw;
   bit m_go, m_ngr, m_wa, m_wb;

   function automatic logic [0:8] mboard(input int who);
      logic [0:8] b;
      for (int i = 0; i < 9; i++) b[i] = (owner[i] == who);
      return b;
   endfunction

   function automatic bit m_turn();
      if (phase == PH_PLAY) return to_move[0];
      if (phase == PH_EVAL) return ~last_mover[0];
      return last_mover[0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) owner[i] = 0;
         phase = PH_PLAY; to_move = 0; last_mover = 0; starter = 0; moves = 0;
         prev_place = 0; prev_ng = 0; m_ill = 0; m_over = 0; m_draw = 0;
      end else begin
         m_go  = place && !prev_place;
         m_ngr = new_game && !prev_ng;
         m_ill = 0;
         if (new_game) begin
            for (int i = 0; i < 9; i++) owner[i] = 0;
            moves = 0; m_over = 0; m_draw = 0;
            if (m_ngr) starter = 1 - starter;
            phase = PH_PLAY;
            to_move = starter;
         end else if (phase == PH_PLAY) begin
            if (m_go) begin
               if (sel > 8 || owner[sel] != 0) begin
                  m_ill = 1;
               end else begin
                  owner[sel] = to_move + 1;
                  moves = (moves < 9) ? moves + 1 : 9;
                  last_mover = to_move;
                  phase = PH_EVAL;
               end
            end
         end else if (phase == PH_EVAL) begin
            m_wa = line_win(mboard(1));
            m_wb = line_win(mboard(2));
            if (m_wa || m_wb || moves == 9) begin
               phase = PH_DONE;
               m_over = 1;
               m_draw = !m_wa && !m_wb && moves == 9;
            end else begin
               phase = PH_PLAY;
               to_move = 1 - last_mover;
            end
         end
         prev_place = place;
         prev_ng = new_game;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("inp1", inp1, mboard(1));
      chk("inp2", inp2, mboard(2));
      chk("disjoint", inp1 & inp2, 0);
      chk("turn", turn, m_turn());
      chk("illegal", illegal, m_ill);
      chk("game_over", game_over, m_over);
      chk("draw", draw, m_draw);
      chk("move_cnt", move_cnt, moves);
   end

   // ---------------- stimulus ----------------
   task automatic do_move(input logic [3:0] s, output bit ill);
      @(negedge clk);
      sel = s;
      place = 1'b1;
      @(negedge clk);
      place = 1'b0;
      ill = illegal;
      @(negedge clk);
   endtask

   task automatic ng_pulse();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
   endtask

   bit ill;
   logic [3:0] seq[9];

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_cnt", move_cnt, 0);
      chk("rst_turn", turn, 0);
      chk("rst_over", game_over, 0);

      // A wins on the top row
      do_move(4'd0, ill); do_move(4'd3, ill); do_move(4'd1, ill);
      do_move(4'd4, ill); do_move(4'd2, ill);
      chk("win_inp1", inp1, 9'b111000000);
      chk("win_inp2", inp2, 9'b000110000);
      chk("win_over", game_over, 1);
      chk("win_draw", draw, 0);
      chk("win_cnt", move_cnt, 5);
      chk("win_turn", turn, 0);
      do_move(4'd5, ill);
      chk("done_noill", ill, 0);
      chk("done_frozen", inp2, 9'b000110000);

      // New game after the win: B opens, then A opens again
      ng_pulse();
      chk("ng1_board", inp1 | inp2, 0);
      chk("ng1_turn", turn, 1);
      ng_pulse();
      chk("ng2_turn", turn, 0);

      // Occupied cell
      do_move(4'd4, ill);
      do_move(4'd4, ill);
      chk("occ_ill", ill, 1);
      chk("occ_inp2", inp2, 0);
      chk("occ_turn", turn, 1);
      chk("occ_cnt", move_cnt, 1);

      // Out-of-range cell in PLAY_A
      ng_pulse(); ng_pulse();
      do_move(4'd12, ill);
      chk("range_ill", ill, 1);
      chk("range_turn", turn, 0);
      chk("range_cnt", move_cnt, 0);

      // Full-board draw
      seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
      for (int i = 0; i < 9; i++) do_move(seq[i], ill);
      chk("draw_draw", draw, 1);
      chk("draw_cnt", move_cnt, 9);
      chk("draw_over", game_over, 1);
      do_move(4'd0, ill);
      chk("draw_noill", ill, 0);
      chk("draw_cnt2", move_cnt, 9);

      // Place held high: a single move
      ng_pulse();
      @(negedge clk);
      sel = 4'd4;
      place = 1'b1;
      repeat (10) @(negedge clk);
      place = 1'b0;
      @(negedge clk);
      chk("hold_cnt", move_cnt, 1);
      chk("hold_inp2", inp2, 9'b000010000);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         sel = 4'($urandom_range(0, 15));
         place = 1'($urandom_range(0, 1));
         new_game = ($urandom_range(0, 24) == 0);
      end
      @(negedge clk);
      place = 1'b0;
      new_game = 1'b0;

      // Asynchronous reset during EVAL
      ng_pulse();
      @(negedge clk);
      sel = 4'd0;
      place = 1'b1;
      @(posedge clk);
      #1;
      chk("eval_cnt", move_cnt, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_inp1", inp1, 0);
      chk("arst_inp2", inp2, 0);
      chk("arst_cnt", move_cnt, 0);
      chk("arst_turn", turn, 0);
      chk("arst_over", game_over, 0);
      @(negedge clk);
      place = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
